// File: rtl/arp_cache_pkg.sv
// Shared types and constants for the ARP cache: FSM state enums, reserved IPs, table entry.
package arp_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } state_w;

  typedef enum logic [2:0] {
    L_IDLE,
    L_COMPARE,
    L_QUERY,
    L_WAIT,
    L_RECHECK,
    L_RESULT
  } state_l;

  localparam logic [31:0] IP_BROADCAST = 32'hFFFF_FFFF;
  localparam logic [31:0] IP_NULL      = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
  } entry_t;

  // Null and broadcast addresses are never stored and never resolved.
  function automatic logic ip_is_reserved(input logic [31:0] ip);
    return (ip == IP_NULL) || (ip == IP_BROADCAST);
  endfunction

endpackage

// File: rtl/arp_cache_if.sv
// Bundle of the ARP cache write channel, lookup channel and ARP query trigger.
interface arp_cache_if;
  logic [31:0] arp_write_ip_in;
  logic        arp_write_valid_in;
  logic        arp_write_ready_out;
  logic [47:0] arp_store_mac_in;
  logic        arp_store_valid_in;
  logic        arp_store_ready_out;
  logic        arp_bvalid_in;
  logic        arp_bready_out;
  logic [31:0] lookup_ip_in;
  logic        lookup_valid_in;
  logic        lookup_ready_out;
  logic [47:0] lookup_mac_out;
  logic        lookup_hit_out;
  logic        lookup_rvalid_out;
  logic        lookup_rready_in;
  logic        trig_arp_qvalid_out;
  logic [31:0] trig_arp_ip_out;
  logic        trig_arp_qready_in;

  modport slave (
    input  arp_write_ip_in, arp_write_valid_in, arp_store_mac_in, arp_store_valid_in,
    input  arp_bvalid_in, lookup_ip_in, lookup_valid_in, lookup_rready_in, trig_arp_qready_in,
    output arp_write_ready_out, arp_store_ready_out, arp_bready_out, lookup_ready_out,
    output lookup_mac_out, lookup_hit_out, lookup_rvalid_out, trig_arp_qvalid_out, trig_arp_ip_out
  );

  modport master (
    output arp_write_ip_in, arp_write_valid_in, arp_store_mac_in, arp_store_valid_in,
    output arp_bvalid_in, lookup_ip_in, lookup_valid_in, lookup_rready_in, trig_arp_qready_in,
    input  arp_write_ready_out, arp_store_ready_out, arp_bready_out, lookup_ready_out,
    input  lookup_mac_out, lookup_hit_out, lookup_rvalid_out, trig_arp_qvalid_out, trig_arp_ip_out
  );
endinterface

// File: rtl/arp_cache_table.sv
// IP->MAC entry storage with parallel match and free/round-robin slot selection.
// Optional entry aging is enabled by defining ARP_CACHE_AGING_EN.
import arp_pkg::*;

module arp_cache_table #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] AGE_LIMIT = 32'd125_000_000,
  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [31:0]   wr_ip_i,
  input  logic [47:0]   wr_mac_i,
  input  logic [31:0]   rd_ip_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o,
  output logic [47:0]   mac_o
);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || AGE_LIMIT == 32'd0) begin : g_bad_cfg
    $error("arp_cache_table: DEPTH must be a power of two in 2..64 and AGE_LIMIT nonzero");
  end

  entry_t        ent_q [DEPTH];
  logic [IW-1:0] ptr_q;

  logic          rd_hit;
  logic [IW-1:0] rd_idx;
  logic [47:0]   rd_mac;
  logic          upd_hit;
  logic [IW-1:0] upd_idx;
  logic          free_hit;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] slot;
  logic          do_commit;

  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = '0;
    rd_mac   = '0;
    upd_hit  = 1'b0;
    upd_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].ip == rd_ip_i && !rd_hit) begin
        rd_hit = 1'b1;
        rd_idx = IW'(i);
        rd_mac = ent_q[i].mac;
      end
      if (ent_q[i].valid && ent_q[i].ip == wr_ip_i && !upd_hit) begin
        upd_hit = 1'b1;
        upd_idx = IW'(i);
      end
      if (!ent_q[i].valid && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    slot      = upd_hit ? upd_idx : (free_hit ? free_idx : ptr_q);
    do_commit = wr_en_i && !ip_is_reserved(wr_ip_i);
  end

  assign hit_o = rd_hit;
  assign idx_o = rd_idx;
  assign mac_o = rd_mac;

`ifdef ARP_CACHE_AGING_EN
  logic [31:0] age_q [DEPTH];

  // Expiry is written first so a same-cycle commit to that slot overrides it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
      ptr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid) begin
          if (age_q[i] == AGE_LIMIT - 32'd1) begin
            ent_q[i].valid <= 1'b0;
            age_q[i]       <= '0;
          end else begin
            age_q[i] <= age_q[i] + 32'd1;
          end
        end
      end
      if (do_commit) begin
        ent_q[slot] <= '{valid: 1'b1, ip: wr_ip_i, mac: wr_mac_i};
        age_q[slot] <= '0;
        if (!upd_hit && !free_hit) ptr_q <= ptr_q + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      ptr_q <= '0;
    end else if (do_commit) begin
      ent_q[slot] <= '{valid: 1'b1, ip: wr_ip_i, mac: wr_mac_i};
      if (!upd_hit && !free_hit) ptr_q <= ptr_q + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/arp_cache.sv
// ARP cache: write-channel responder, IP->MAC lookup with ARP query on miss and timeout.
// Define ARP_CACHE_AGING_EN to expire entries after AGE_LIMIT cycles.
import arp_pkg::*;

module arp_cache #(
  parameter int unsigned DEPTH         = 8,
  parameter logic [15:0] QUERY_TIMEOUT = 16'd50000,
  parameter logic [31:0] AGE_LIMIT     = 32'd125_000_000
) (
  input logic        logic_clk,
  input logic        logic_rst_n,
  arp_cache_if.slave bus
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_w      w_state_q, w_state_d;
  logic [31:0] w_ip_q, w_ip_d;
  logic        w_ready_q, s_ready_q, b_ready_q;
  logic        commit;
  logic        bresp_hs;

  state_l      l_state_q, l_state_d;
  logic [31:0] l_ip_q, l_ip_d;
  logic [15:0] cnt_q, cnt_d;
  logic        l_ready_q, rvalid_q, qvalid_q;
  logic        hit_q, hit_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] qip_q;

  logic          tbl_hit;
  logic [IW-1:0] tbl_idx;
  logic [47:0]   tbl_mac;
  logic          unused_idx;

  assign bresp_hs   = bus.arp_bvalid_in & b_ready_q;
  assign unused_idx = ^tbl_idx;

  arp_cache_table #(
    .DEPTH    (DEPTH),
    .AGE_LIMIT(AGE_LIMIT)
  ) u_table (
    .clk_i   (logic_clk),
    .rst_n_i (logic_rst_n),
    .wr_en_i (commit),
    .wr_ip_i (w_ip_q),
    .wr_mac_i(bus.arp_store_mac_in),
    .rd_ip_i (l_ip_q),
    .hit_o   (tbl_hit),
    .idx_o   (tbl_idx),
    .mac_o   (tbl_mac)
  );

  always_comb begin
    w_state_d = w_state_q;
    w_ip_d    = w_ip_q;
    commit    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (bus.arp_write_valid_in && w_ready_q) begin
          w_ip_d    = bus.arp_write_ip_in;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.arp_store_valid_in && s_ready_q) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bresp_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Readies are registered from the next state so each is high exactly in its own state.
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      w_state_q <= W_IDLE;
      w_ip_q    <= '0;
      w_ready_q <= 1'b0;
      s_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_ip_q    <= w_ip_d;
      w_ready_q <= (w_state_d == W_IDLE);
      s_ready_q <= (w_state_d == W_DATA);
      b_ready_q <= (w_state_d == W_RESP);
    end
  end

  always_comb begin
    l_state_d = l_state_q;
    l_ip_d    = l_ip_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    mac_d     = mac_q;
    unique case (l_state_q)
      L_IDLE: begin
        if (bus.lookup_valid_in && l_ready_q) begin
          l_ip_d    = bus.lookup_ip_in;
          l_state_d = L_COMPARE;
        end
      end
      L_COMPARE: begin
        if (ip_is_reserved(l_ip_q)) begin
          hit_d     = 1'b0;
          mac_d     = '0;
          l_state_d = L_RESULT;
        end else if (tbl_hit) begin
          hit_d     = 1'b1;
          mac_d     = tbl_mac;
          l_state_d = L_RESULT;
        end else begin
          cnt_d     = '0;
          l_state_d = L_QUERY;
        end
      end
      L_QUERY: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == QUERY_TIMEOUT - 16'd1) begin
          hit_d     = 1'b0;
          mac_d     = '0;
          l_state_d = L_RESULT;
        end else if (bus.trig_arp_qready_in) begin
          l_state_d = bresp_hs ? L_RECHECK : L_WAIT;
        end
      end
      L_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == QUERY_TIMEOUT - 16'd1) begin
          hit_d     = 1'b0;
          mac_d     = '0;
          l_state_d = L_RESULT;
        end else if (bresp_hs) begin
          l_state_d = L_RECHECK;
        end
      end
      L_RECHECK: begin
        hit_d     = tbl_hit;
        mac_d     = tbl_hit ? tbl_mac : '0;
        l_state_d = L_RESULT;
      end
      L_RESULT: begin
        if (bus.lookup_rready_in && rvalid_q) begin
          hit_d     = 1'b0;
          mac_d     = '0;
          l_state_d = L_IDLE;
        end
      end
      default: l_state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      l_state_q <= L_IDLE;
      l_ip_q    <= '0;
      cnt_q     <= '0;
      l_ready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      qvalid_q  <= 1'b0;
      qip_q     <= '0;
      hit_q     <= 1'b0;
      mac_q     <= '0;
    end else begin
      l_state_q <= l_state_d;
      l_ip_q    <= l_ip_d;
      cnt_q     <= cnt_d;
      l_ready_q <= (l_state_d == L_IDLE);
      rvalid_q  <= (l_state_d == L_RESULT);
      qvalid_q  <= (l_state_d == L_QUERY);
      qip_q     <= (l_state_d == L_QUERY) ? l_ip_d : '0;
      hit_q     <= hit_d;
      mac_q     <= mac_d;
    end
  end

  assign bus.arp_write_ready_out = w_ready_q;
  assign bus.arp_store_ready_out = s_ready_q;
  assign bus.arp_bready_out      = b_ready_q;
  assign bus.lookup_ready_out    = l_ready_q;
  assign bus.lookup_rvalid_out   = rvalid_q;
  assign bus.lookup_hit_out      = hit_q;
  assign bus.lookup_mac_out      = mac_q;
  assign bus.trig_arp_qvalid_out = qvalid_q;
  assign bus.trig_arp_ip_out     = qip_q;

endmodule

// File: tb/tb_arp_cache.sv
// Randomized self-checking bench for arp_cache against an array-based cache model.
module tb_arp_cache;

  localparam int QT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  arp_cache_if bus ();

  arp_cache #(
    .DEPTH        (8),
    .QUERY_TIMEOUT(16'd100),
    .AGE_LIMIT    (32'd50)
  ) dut (
    .logic_clk  (clk),
    .logic_rst_n(rst_n),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a plain 8-slot table with the documented slot-selection rules.
  logic [31:0] m_ip  [8];
  logic [47:0] m_mac [8];
  bit          m_v   [8];
  int          m_ptr;

  function automatic void m_reset();
    foreach (m_v[i]) m_v[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic void m_commit(input logic [31:0] ip, input logic [47:0] mac);
    int slot;
    slot = -1;
    if (ip == 32'h0 || ip == 32'hFFFF_FFFF) return;
    foreach (m_v[i]) if (slot < 0 && m_v[i] && m_ip[i] == ip) slot = i;
    if (slot < 0) foreach (m_v[i]) if (slot < 0 && !m_v[i]) slot = i;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % 8;
    end
    m_v[slot]   = 1'b1;
    m_ip[slot]  = ip;
    m_mac[slot] = mac;
  endfunction

  function automatic bit m_find(input logic [31:0] ip, output logic [47:0] mac);
    mac = '0;
    if (ip == 32'h0 || ip == 32'hFFFF_FFFF) return 1'b0;
    foreach (m_v[i]) if (m_v[i] && m_ip[i] == ip) begin
      mac = m_mac[i];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [47:0] rand_mac();
    return {16'($urandom()), $urandom()};
  endfunction

  task automatic do_write(input logic [31:0] ip, input logic [47:0] mac, output int c_store);
    int n;
    c_store = 0;
    @(negedge clk);
    for (n = 0; n < 200 && !bus.arp_write_ready_out; n++) @(negedge clk);
    if (!bus.arp_write_ready_out) begin
      checks++; errors++;
      $display("FAIL wr_addr_wait got ready=0 exp ready=1");
      return;
    end
    bus.arp_write_ip_in = ip;
    bus.arp_write_valid_in = 1'b1;
    @(posedge clk); #1 bus.arp_write_valid_in = 1'b0;
    @(negedge clk);
    for (n = 0; n < 20 && !bus.arp_store_ready_out; n++) @(negedge clk);
    if (!bus.arp_store_ready_out) begin
      checks++; errors++;
      $display("FAIL wr_data_wait got ready=0 exp ready=1");
      return;
    end
    bus.arp_store_mac_in = mac;
    bus.arp_store_valid_in = 1'b1;
    @(posedge clk); #1 bus.arp_store_valid_in = 1'b0;
    c_store = cyc;
    m_commit(ip, mac);
    @(negedge clk);
    for (n = 0; n < 20 && !bus.arp_bready_out; n++) @(negedge clk);
    if (!bus.arp_bready_out) begin
      checks++; errors++;
      $display("FAIL wr_resp_wait got bready=0 exp bready=1");
      return;
    end
    bus.arp_bvalid_in = 1'b1;
    @(posedge clk); #1 bus.arp_bvalid_in = 1'b0;
  endtask

  // Issues one lookup; when a query appears it pulses qready and, if asked, writes the reply.
  task automatic do_lookup(input logic [31:0] ip, input bit respond, input logic [31:0] rip,
                           input logic [47:0] rmac, input int at_cyc,
                           output bit hit, output logic [47:0] mac, output int lat,
                           output bit qseen, output int qcyc, output bit q_at_r);
    int n, dummy;
    bit done;
    hit = 0; mac = '0; lat = 0; qseen = 0; qcyc = 0; q_at_r = 0; done = 0;
    @(negedge clk);
    while (cyc < at_cyc) @(negedge clk);
    for (n = 0; n < 200 && !bus.lookup_ready_out; n++) @(negedge clk);
    if (!bus.lookup_ready_out) begin
      checks++; errors++;
      $display("FAIL lk_ready_wait got ready=0 exp ready=1");
      return;
    end
    bus.lookup_ip_in = ip;
    bus.lookup_valid_in = 1'b1;
    @(posedge clk); #1 bus.lookup_valid_in = 1'b0;
    for (n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      lat++;
      if (bus.lookup_rvalid_out) begin
        done = 1;
        q_at_r = bus.trig_arp_qvalid_out;
      end else if (bus.trig_arp_qvalid_out) begin
        qcyc++;
        if (!qseen) begin
          qseen = 1;
          checks++;
          if (bus.trig_arp_ip_out !== ip) begin
            errors++;
            $display("FAIL trig_ip got %h exp %h", bus.trig_arp_ip_out, ip);
          end
          if (respond) begin
            bus.trig_arp_qready_in = 1'b1;
            @(posedge clk); #1 bus.trig_arp_qready_in = 1'b0;
            do_write(rip, rmac, dummy);
          end
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL lk_result_wait got rvalid=0 exp rvalid=1");
      return;
    end
    hit = bus.lookup_hit_out;
    mac = bus.lookup_mac_out;
    bus.lookup_rready_in = 1'b1;
    @(posedge clk); #1 bus.lookup_rready_in = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.arp_write_ready_out, bus.arp_store_ready_out, bus.arp_bready_out, bus.lookup_ready_out,
         bus.lookup_rvalid_out, bus.lookup_hit_out, bus.lookup_mac_out, bus.trig_arp_qvalid_out,
         bus.trig_arp_ip_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b st=%b b=%b lk=%b rv=%b hit=%b mac=%h qv=%b qip=%h exp all 0",
               bus.arp_write_ready_out, bus.arp_store_ready_out, bus.arp_bready_out, bus.lookup_ready_out,
               bus.lookup_rvalid_out, bus.lookup_hit_out, bus.lookup_mac_out, bus.trig_arp_qvalid_out,
               bus.trig_arp_ip_out);
    end
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({bus.arp_write_ready_out, bus.lookup_ready_out, bus.arp_store_ready_out} !== 3'b110) begin
      errors++;
      $display("FAIL idle_readies got %b exp 110",
               {bus.arp_write_ready_out, bus.lookup_ready_out, bus.arp_store_ready_out});
    end
  endtask

  task automatic test_write_hit();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc, c;
    do_write(32'hC0A8_0002, 48'h0200_0000_0002, c);
    do_lookup(32'hC0A8_0002, 0, 0, 0, 0, hit, mac, lat, qs, qc, qr);
    checks++;
    if ({hit, mac, qs} !== {1'b1, 48'h0200_0000_0002, 1'b0}) begin
      errors++;
      $display("FAIL hit_result got hit=%b mac=%h q=%b exp hit=1 mac=020000000002 q=0", hit, mac, qs);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL hit_latency got %0d exp 2", lat);
    end
  endtask

  task automatic test_miss_reply();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc;
    do_lookup(32'hC0A8_0009, 1, 32'hC0A8_0009, 48'h1122_3344_5566, 0, hit, mac, lat, qs, qc, qr);
    checks++;
    if ({qs, hit, mac} !== {1'b1, 1'b1, 48'h1122_3344_5566}) begin
      errors++;
      $display("FAIL miss_reply got q=%b hit=%b mac=%h exp q=1 hit=1 mac=112233445566", qs, hit, mac);
    end
  endtask

  task automatic test_timeout();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc;
    do_lookup(32'hC0A8_00EE, 0, 0, 0, 0, hit, mac, lat, qs, qc, qr);
    checks++;
    if (qc !== QT) begin
      errors++;
      $display("FAIL timeout_qcycles got %0d exp %0d", qc, QT);
    end
    checks++;
    if ({hit, mac, qr} !== '0) begin
      errors++;
      $display("FAIL timeout_result got hit=%b mac=%h qv=%b exp 0 0 0", hit, mac, qr);
    end
  endtask

  task automatic test_special_lookup();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc;
    logic [31:0] sp [2];
    sp[0] = 32'h0; sp[1] = 32'hFFFF_FFFF;
    foreach (sp[k]) begin
      do_lookup(sp[k], 1, 32'h0, 0, 0, hit, mac, lat, qs, qc, qr);
      checks++;
      if ({qs, hit, mac} !== '0 || lat !== 2) begin
        errors++;
        $display("FAIL special_lookup ip=%h got q=%b hit=%b mac=%h lat=%0d exp 0 0 0 lat 2",
                 sp[k], qs, hit, mac, lat);
      end
    end
  endtask

  task automatic check_all_lookups(input logic [31:0] base, input int n, input string tag);
    bit hit, qs, qr, eh; logic [47:0] mac, em; int lat, qc;
    for (int i = 0; i < n; i++) begin
      eh = m_find(base + 32'(i), em);
      do_lookup(base + 32'(i), 1, 32'h0, 0, 0, hit, mac, lat, qs, qc, qr);
      checks++;
      if ({hit, mac} !== {eh, em}) begin
        errors++;
        $display("FAIL %s ip=%h got hit=%b mac=%h exp hit=%b mac=%h", tag, base + 32'(i), hit, mac, eh, em);
      end
    end
  endtask

  task automatic test_replace();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc, c;
    apply_reset();
    for (int i = 0; i < 9; i++) do_write(32'h0A01_0001 + 32'(i), rand_mac(), c);
    do_lookup(32'h0A01_0001, 1, 32'h0, 0, 0, hit, mac, lat, qs, qc, qr);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL evict_slot0 got hit=%b exp hit=0", hit);
    end
    check_all_lookups(32'h0A01_0001, 9, "after_fill");
    do_write(32'h0A01_0004, 48'hABCD_EF01_2345, c);
    do_write(32'h0A01_000A, rand_mac(), c);
    check_all_lookups(32'h0A01_0001, 10, "after_update");
  endtask

  task automatic test_random();
    bit hit, qs, qr, pre, eh; logic [47:0] mac, em, rm; int lat, qc, c;
    logic [31:0] ip, rip;
    for (int t = 0; t < 40; t++) begin
      ip = 32'h0A00_0001 + 32'($urandom_range(0, 11));
      if ($urandom_range(0, 9) < 5) begin
        do_write(ip, rand_mac(), c);
      end else begin
        pre = m_find(ip, em);
        rip = $urandom_range(0, 1) ? ip : 32'h0;
        rm  = rand_mac();
        do_lookup(ip, 1, rip, rm, 0, hit, mac, lat, qs, qc, qr);
        eh = m_find(ip, em);
        checks++;
        if ({qs, hit, mac} !== {~pre, eh, em}) begin
          errors++;
          $display("FAIL random_lookup ip=%h got q=%b hit=%b mac=%h exp q=%b hit=%b mac=%h",
                   ip, qs, hit, mac, ~pre, eh, em);
        end
      end
    end
  endtask

  task automatic test_hold();
    int n, c;
    logic [48:0] cap;
    do_write(32'hC0A8_0042, 48'h0042_4242_4242, c);
    @(negedge clk);
    for (n = 0; n < 50 && !bus.lookup_ready_out; n++) @(negedge clk);
    bus.lookup_ip_in = 32'hC0A8_0042;
    bus.lookup_valid_in = 1'b1;
    @(posedge clk); #1 bus.lookup_valid_in = 1'b0;
    @(negedge clk);
    for (n = 0; n < 50 && !bus.lookup_rvalid_out; n++) @(negedge clk);
    cap = {bus.lookup_hit_out, bus.lookup_mac_out};
    checks++;
    if (cap !== {1'b1, 48'h0042_4242_4242}) begin
      errors++;
      $display("FAIL hold_initial got %h exp %h", cap, {1'b1, 48'h0042_4242_4242});
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({bus.lookup_rvalid_out, bus.lookup_hit_out, bus.lookup_mac_out} !== {1'b1, cap}) begin
        errors++;
        $display("FAIL hold_stable got rv=%b %h exp rv=1 %h", bus.lookup_rvalid_out,
                 {bus.lookup_hit_out, bus.lookup_mac_out}, cap);
      end
    end
    bus.lookup_rready_in = 1'b1;
    @(posedge clk); #1 bus.lookup_rready_in = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc, n;
    @(negedge clk);
    for (n = 0; n < 50 && !bus.arp_write_ready_out; n++) @(negedge clk);
    bus.arp_write_ip_in = 32'hC0A8_0077;
    bus.arp_write_valid_in = 1'b1;
    @(posedge clk); #1 bus.arp_write_valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.arp_store_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_wdata got store_ready=%b exp 1", bus.arp_store_ready_out);
    end
    bus.arp_store_mac_in = 48'h7777_7777_7777;
    apply_reset();
    do_lookup(32'hC0A8_0077, 1, 32'h0, 0, 0, hit, mac, lat, qs, qc, qr);
    checks++;
    if ({qs, hit, mac} !== {1'b1, 1'b0, 48'h0}) begin
      errors++;
      $display("FAIL after_reset_lookup got q=%b hit=%b mac=%h exp q=1 hit=0 mac=0", qs, hit, mac);
    end
    check_all_lookups(32'hC0A8_0040, 4, "after_reset_table");
  endtask

`ifdef ARP_CACHE_AGING_EN
  task automatic test_aging();
    bit hit, qs, qr; logic [47:0] mac; int lat, qc, c0;
    apply_reset();
    do_write(32'h0A0B_0C0D, 48'h0000_AAAA_0001, c0);
    do_lookup(32'h0A0B_0C0D, 0, 0, 0, c0 + 48, hit, mac, lat, qs, qc, qr);
    checks++;
    if ({hit, qs, mac} !== {1'b1, 1'b0, 48'h0000_AAAA_0001}) begin
      errors++;
      $display("FAIL age_49 got hit=%b q=%b mac=%h exp hit=1 q=0 mac=0000aaaa0001", hit, qs, mac);
    end
    do_write(32'h0A0B_0C0E, 48'h0000_AAAA_0002, c0);
    do_lookup(32'h0A0B_0C0E, 1, 32'h0, 0, c0 + 50, hit, mac, lat, qs, qc, qr);
    checks++;
    if ({hit, qs} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL age_51 got hit=%b q=%b exp hit=0 q=1", hit, qs);
    end
  endtask
`endif

  initial begin
    bus.arp_write_ip_in    = '0;
    bus.arp_write_valid_in = 1'b0;
    bus.arp_store_mac_in   = '0;
    bus.arp_store_valid_in = 1'b0;
    bus.arp_bvalid_in      = 1'b0;
    bus.lookup_ip_in       = '0;
    bus.lookup_valid_in    = 1'b0;
    bus.lookup_rready_in   = 1'b0;
    bus.trig_arp_qready_in = 1'b0;
    test_reset();
    test_write_hit();
    test_special_lookup();
`ifdef ARP_CACHE_AGING_EN
    test_aging();
`else
    test_miss_reply();
    test_timeout();
    test_hold();
    test_replace();
    test_random();
    test_reset_mid_write();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arp_cache.md
Name: arp_cache

Overview:
- Responder end of the ARP cache write channel (write_ip / store_mac / bvalid) driven by the ARP engine.
- Stores up to DEPTH IP→MAC bindings and serves IP→MAC lookups to the IP/UDP transmit path.
- On a lookup miss, it drives the ARP engine's query trigger, waits for the reply to be written back, then re-checks the table.

Parameters:
- DEPTH, 8: number of cache entries; power of two, 2..64.
- QUERY_TIMEOUT, 16'd50000: cycles allowed in L_QUERY+L_WAIT before reporting a miss.
- AGE_LIMIT, 32'd125_000_000: entry lifetime in cycles; used only with the optional feature.

Ports:
- logic_clk  in  1  clock.
- logic_rst_n  in  1  synchronous active-low reset.
- arp_write_ip_in  in  32  IP for the write; address phase.
- arp_write_valid_in  in  1  address-phase valid.
- arp_write_ready_out  out  1  address-phase ready.
- arp_store_mac_in  in  48  MAC for the write; data phase.
- arp_store_valid_in  in  1  data-phase valid.
- arp_store_ready_out  out  1  data-phase ready.
- arp_bvalid_in  in  1  write-response valid, from the writer.
- arp_bready_out  out  1  write-response ready.
- lookup_ip_in  in  32  IP to resolve.
- lookup_valid_in  in  1  lookup request valid.
- lookup_ready_out  out  1  lookup request ready.
- lookup_mac_out  out  48  resolved MAC; 0 on miss.
- lookup_hit_out  out  1  1 = hit.
- lookup_rvalid_out  out  1  result valid.
- lookup_rready_in  in  1  result ready.
- trig_arp_qvalid_out  out  1  ARP query request.
- trig_arp_ip_out  out  32  IP being queried.
- trig_arp_qready_in  in  1  one-cycle pulse: a matching reply was received.

Behaviour:
- Reset (logic_rst_n=0 at a clock edge):
  - all entries invalid; both FSMs go to their idle state;
  - every output is 0; the round-robin pointer is 0.
  - Reset mid-transaction abandons it; no partial entry is committed.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: arp_write_ready_out=1. On arp_write_valid_in: latch the IP, go to W_DATA.
  - W_DATA: arp_store_ready_out=1. On arp_store_valid_in: latch the MAC, commit at that edge, go to W_RESP.
  - W_RESP: arp_bready_out=1. On arp_bvalid_in: go to W_IDLE.
  - Each ready is a registered level, 1 only in its own state.
- Commit slot, in priority order:
  - an existing valid entry with the same IP is updated in place;
  - otherwise the lowest-index invalid entry;
  - otherwise the entry at the round-robin pointer, then pointer+1 modulo DEPTH.
- Writing IP 0 or 32'hFFFF_FFFF is acknowledged normally but not committed.
- Lookup FSM states: L_IDLE, L_COMPARE, L_QUERY, L_WAIT, L_RECHECK, L_RESULT.
  - L_IDLE: lookup_ready_out=1. On lookup_valid_in: latch the IP, go to L_COMPARE.
  - L_COMPARE: parallel compare against registered table contents.
    - Hit: go to L_RESULT. Result valid 2 cycles after request acceptance.
    - Miss: go to L_QUERY.
  - L_QUERY: trig_arp_qvalid_out=1 and trig_arp_ip_out=latched IP, both held.
    - On trig_arp_qready_in: drop qvalid, go to L_WAIT.
  - L_WAIT: on an arp_bvalid_in & arp_bready_out handshake, go to L_RECHECK. If that handshake falls in the same cycle as the qready pulse, go straight to L_RECHECK from L_QUERY.
  - L_RECHECK: compare again; a hit or a miss both go to L_RESULT.
  - L_RESULT: lookup_rvalid_out=1, with mac/hit held stable until lookup_rready_in, then L_IDLE.
- Timeout:
  - A 16-bit counter is cleared on entering L_QUERY and counts in L_QUERY and L_WAIT.
  - At QUERY_TIMEOUT: qvalid=0, go to L_RESULT with hit=0.
- A commit and a compare in the same cycle: the compare sees pre-commit contents.
- Lookup of IP 0 or 32'hFFFF_FFFF: immediate miss in L_COMPARE; no query is issued.

Optional Feature:
- Macro ARP_CACHE_AGING_EN.
- Defined:
  - each entry carries a 32-bit age counter, cleared on commit and incremented every cycle while valid;
  - reaching AGE_LIMIT invalidates the entry;
  - an invalidation and a commit to the same slot in the same cycle resolve in favour of the commit.
- Undefined: entries stay valid until overwritten or reset; no age counters are synthesized.

Decomposition:
- Package arp_pkg holds:
  - the state_w and state_l enums;
  - IP_BROADCAST=32'hFFFF_FFFF and IP_NULL=32'h0;
  - the entry struct {valid, ip[31:0], mac[47:0]}.
- One natural sub-module, arp_cache_table: entry storage, parallel match, free/replace selection, and aging. Outputs hit/index/mac.

Test Plan:
- Write 192.168.0.2→MAC 02:00:00:00:00:02, then look up 192.168.0.2 → rvalid 2 cycles after acceptance, hit=1, mac=48'h0200_0000_0002, no trig_arp_qvalid_out.
- Look up 192.168.0.9 on an empty cache → trig_arp_qvalid_out=1 with ip C0A8_0009. Pulse qready, then complete a write of C0A8_0009→48'h1122_3344_5566 → L_RECHECK gives hit=1 with that MAC.
- Miss with no reply, QUERY_TIMEOUT=100 → qvalid drops and rvalid rises with hit=0 on the 100th counted cycle.
- Fill 8 entries, then write a 9th IP → entry 0 replaced. Rewrite an existing IP with a new MAC → no replacement, MAC updated, pointer unchanged.
- Hold lookup_rready_in=0 for 20 cycles → mac/hit/rvalid stable. Assert logic_rst_n=0 mid-W_DATA → after reset, a lookup of that IP misses and all outputs are 0.
- With ARP_CACHE_AGING_EN and AGE_LIMIT=50 → a lookup 49 cycles after commit hits; a lookup at 51 cycles misses and triggers a query.
